// File: rtl/cache_line_fill.sv
// cache_line_fill: per-cache miss handler that issues one burst read and assembles a full line
//
// Accepts one line miss from the cache and issues a single burst read to one arbiter read port.
// Returned words are packed into a line buffer, and the finished line is then held for the cache.
//
// Ports
//   clk, rst_l                  clock; asynchronous active-low reset
//   miss_valid/miss_addr        miss request from the cache (word address)
//   miss_ready                  high only while idle
//   line_valid/line_addr        assembled line and its line-aligned base address
//   line_data/line_err          line words (word k at [32k+31:32k]) and short/late flag
//   line_ready                  cache consumes the line
//   readReq/addr/transSize      burst read request to the arbiter
//   readValid/readData          returned words from the arbiter
//   doneRead                    burst-complete pulse from the arbiter
//
// Optional feature: define FILL_TIMEOUT_EN to add a watchdog. If doneRead has not arrived after
// TIMEOUT_CYC cycles in REQ, the watchdog ends the burst and flags line_err.
module cache_line_fill #(
    parameter int LINE_WORDS  = 8,
    parameter int ADDR_W      = 25,
    parameter int MAX_TRANS   = 64,
    parameter int TIMEOUT_CYC = 1024,
    localparam int TS_W       = $clog2(MAX_TRANS)
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     miss_valid,
    input  logic [ADDR_W-1:0]        miss_addr,
    output logic                     miss_ready,
    output logic                     line_valid,
    output logic [ADDR_W-1:0]        line_addr,
    output logic [LINE_WORDS*32-1:0] line_data,
    output logic                     line_err,
    input  logic                     line_ready,
    output logic                     readReq,
    output logic [ADDR_W-1:0]        addr,
    output logic [TS_W-1:0]          transSize,
    input  logic                     readValid,
    input  logic [31:0]              readData,
    input  logic                     doneRead
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int CW = IW + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [CW-1:0] FULL = CW'(LINE_WORDS);

    if (LINE_WORDS < 2 || LINE_WORDS > 32 || LINE_WORDS >= MAX_TRANS || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("cache_line_fill: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic [LINE_WORDS-1:0][31:0]     data_q, data_d;
    logic                            tmo_hit;

`ifdef FILL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    // Counter is zero outside REQ, so it is cleared on every entry into REQ.
    assign tmo_hit = (state_q == REQ) && (tmo_q == TW'(TIMEOUT_CYC - 1));
    always_comb tmo_d = (state_q == REQ) ? tmo_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    base_d  = miss_addr & ~LINE_MASK;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    data_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Surplus words beyond a full line are dropped and flagged.
                if (readValid) begin
                    if (cnt_q < FULL) begin
                        data_d[cnt_q[IW-1:0]] = readData;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A word arriving with doneRead is counted before the short-line test.
                if (doneRead) begin
                    state_d = OUT;
                    if (cnt_d < FULL) err_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d = OUT;
                    err_d   = 1'b1;
                end
            end
            OUT: begin
                if (line_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign miss_ready = (state_q == IDLE);
    assign readReq    = (state_q == REQ);
    assign addr       = readReq ? base_q : '0;
    assign transSize  = readReq ? TS_W'(LINE_WORDS) : '0;
    assign line_valid = (state_q == OUT);
    assign line_addr  = base_q;
    assign line_data  = data_q;
    assign line_err   = err_q;
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: scoreboard bench driving an arbiter model against cache_line_fill
module tb_cache_line_fill;
    logic         clk = 0;
    logic         rst_l;
    logic         miss_valid, line_ready, readValid, doneRead;
    logic [24:0]  miss_addr;
    logic [31:0]  readData;
    logic         miss_ready, line_valid, line_err, readReq;
    logic [24:0]  line_addr, addr;
    logic [255:0] line_data;
    logic [5:0]   transSize;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [24:0]  a;
        logic [255:0] d;
        logic         e;
    } exp_t;
    exp_t sb[$];

    cache_line_fill #(.LINE_WORDS(8), .ADDR_W(25), .MAX_TRANS(64), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_l(rst_l),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data),
        .line_err(line_err), .line_ready(line_ready),
        .readReq(readReq), .addr(addr), .transSize(transSize),
        .readValid(readValid), .readData(readData), .doneRead(doneRead)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mready"}, 256'(miss_ready), 256'(1));
        check({tag, "_req"},    256'(readReq),    256'(0));
        check({tag, "_addr"},   256'(addr),       256'(0));
        check({tag, "_tsize"},  256'(transSize),  256'(0));
        check({tag, "_lvalid"}, 256'(line_valid), 256'(0));
        check({tag, "_laddr"},  256'(line_addr),  256'(0));
        check({tag, "_ldata"},  line_data,        256'(0));
        check({tag, "_lerr"},   256'(line_err),   256'(0));
    endtask

    task automatic wait_req();
        for (int i = 0; i < 10 && !readReq; i++) tick();
        check("req_seen", 256'(readReq), 256'(1));
    endtask

    // Miss, arbiter returns n words (gap idle cycles between them, doneRead with the last),
    // then the cache holds line_ready low for hold cycles before consuming.
    task automatic do_miss(input logic [24:0] a, input int n, input int gap,
                           input logic [31:0] first, input int hold);
        exp_t e;
        exp_t x;
        logic [255:0] held;
        e.a = a & ~25'd7;
        e.d = '0;
        e.e = (n != 8);
        for (int i = 0; i < n && i < 8; i++) e.d[32*i +: 32] = first + 32'(i);
        sb.push_back(e);
        miss_valid = 1;
        miss_addr  = a;
        tick();
        miss_valid = 0;
        check("mready_busy", 256'(miss_ready), 256'(0));
        wait_req();
        check("req_addr", 256'(addr), 256'(e.a));
        check("req_tsize", 256'(transSize), 256'(8));
        for (int i = 0; i < n; i++) begin
            readValid = 1;
            readData  = first + 32'(i);
            doneRead  = (i == n - 1);
            tick();
            readValid = 0;
            doneRead  = 0;
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    check("gap_req", 256'(readReq), 256'(1));
                    check("gap_addr", 256'(addr), 256'(e.a));
                    tick();
                end
            end
        end
        check("line_valid", 256'(line_valid), 256'(1));
        x = sb.pop_front();
        check("line_addr", 256'(line_addr), 256'(x.a));
        check("line_data", line_data, x.d);
        check("line_err", 256'(line_err), 256'(x.e));
        held = line_data;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 256'(line_valid), 256'(1));
            check("hold_data", line_data, held);
            check("hold_mready", 256'(miss_ready), 256'(0));
            check("hold_req", 256'(readReq), 256'(0));
        end
        line_ready = 1;
        tick();
        line_ready = 0;
        check("consumed", 256'(line_valid), 256'(0));
        check("mready_again", 256'(miss_ready), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stuck;
        rst_l = 0; miss_valid = 0; miss_addr = '0; line_ready = 0;
        readValid = 0; readData = '0; doneRead = 0;
        #3;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_l = 1;
        tick();

        do_miss(25'h0A5A5A5, 8, 0, 32'h100, 0);
        do_miss(25'h1234567, 8, 3, 32'h300, 5);
        do_miss(25'h0000ABC, 6, 0, 32'hDEADBEEF, 0);
        do_miss(25'h0000040, 9, 0, 32'h500, 1);

        // Reset in the middle of a burst, then stray arbiter activity while idle.
        miss_valid = 1;
        miss_addr  = 25'h0000123;
        tick();
        miss_valid = 0;
        wait_req();
        for (int i = 0; i < 3; i++) begin
            readValid = 1;
            readData  = 32'h700 + 32'(i);
            tick();
        end
        readValid = 0;
        rst_l = 0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_l = 1;
        readValid = 1; readData = 32'h55; doneRead = 1;
        tick();
        readValid = 0; doneRead = 0;
        tick();
        check("stray_mready", 256'(miss_ready), 256'(1));
        check("stray_lvalid", 256'(line_valid), 256'(0));
        check("stray_req", 256'(readReq), 256'(0));
        check("stray_data", line_data, 256'(0));
        do_miss(25'h0000123, 8, 1, 32'h200, 2);

        // No doneRead at all.
        miss_valid = 1;
        miss_addr  = 25'h0000100;
        tick();
        miss_valid = 0;
        wait_req();
`ifdef FILL_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("tmo_req_still", 256'(readReq), 256'(1));
        tick();
        check("tmo_lvalid", 256'(line_valid), 256'(1));
        check("tmo_req_drop", 256'(readReq), 256'(0));
        check("tmo_lerr", 256'(line_err), 256'(1));
        check("tmo_ldata", line_data, 256'(0));
`else
        stuck = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!readReq || line_valid) stuck++;
        end
        check("no_timeout", 256'(stuck), 256'(0));
`endif
        rst_l = 0;
        #1;
        check_reset_outputs("endrst");
        tick();
        rst_l = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
